// File: rtl/kpn_lcd_pkg.sv
// Shared types and constants for the KPN result-to-LCD path.
package kpn_lcd_pkg;

    // Formatter sequencing states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam int              LCD_CHAR_W = 8;
    localparam logic [LCD_CHAR_W-1:0] ASCII_ZERO = 8'h30;

    // Map one BCD digit onto its ASCII character.
    function automatic logic [LCD_CHAR_W-1:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_ZERO + {4'h0, digit};
    endfunction

endpackage : kpn_lcd_pkg

// File: rtl/result_bcd_formatter_bin2bcd_step.sv
// One double-dabble step: add 3 to every BCD nibble >= 5, then shift
// the concatenation {bcd, shift} left by one bit.
module bin2bcd_step #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic [DATA_W-1:0]   shift_in,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [DATA_W-1:0]   shift_out
);

    logic [4*DIGITS-1:0] bcd_adj;

    // Per-nibble correction so the following shift carries correctly into the next decade.
    always_comb begin
        bcd_adj = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
    end

    assign {bcd_out, shift_out} = {bcd_adj, shift_in} << 1;

endmodule : bin2bcd_step

// File: rtl/result_bcd_formatter.sv
// Captures the divider quotient on a rising result flag, converts it to
// decimal with a sequential double-dabble and streams the digits as ASCII
// characters over a valid/ready handshake.
module result_bcd_formatter
    import kpn_lcd_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int DIGITS         = 5,
    parameter bit SUPPRESS_ZEROS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     result_in,
    input  logic                  result_valid,
    output logic [LCD_CHAR_W-1:0] char_out,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int STEP_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(DIGITS - 1);

    state_t                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic [DATA_W-1:0]       shift_q, shift_d;
    logic [4*DIGITS-1:0]     bcd_q, bcd_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [LCD_CHAR_W-1:0]   char_out_q, char_out_d;
    logic                    char_valid_q, char_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    trigger;
    logic [4*DIGITS-1:0]     step_bcd;
    logic [DATA_W-1:0]       step_shift;
    logic [IDX_W-1:0]        start_idx;
    logic [IDX_W-1:0]        idx_dec;

    assign trigger = result_valid && !valid_q;
    assign idx_dec = idx_q - 1'b1;

    bin2bcd_step #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_step (
        .bcd_in    (bcd_q),
        .shift_in  (shift_q),
        .bcd_out   (step_bcd),
        .shift_out (step_shift)
    );

    // Pick the first digit to send from the fully converted BCD value.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        start_idx = '0;
        if (SUPPRESS_ZEROS) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (step_bcd[4*i +: 4] != 4'd0) begin
                    start_idx = IDX_W'(i);
                end
            end
        end else begin
            start_idx = IDX_TOP;
        end
    end

    // Next-state and next-output logic for the capture/convert/emit sequence.
    always_comb begin
        state_d      = state_q;
        valid_d      = result_valid;
        shift_d      = shift_q;
        bcd_d        = bcd_q;
        step_d       = step_q;
        idx_d        = idx_q;
        char_out_d   = char_out_q;
        char_valid_d = char_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    shift_d = result_in;
                    bcd_d   = '0;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end

            CONVERT: begin
                bcd_d   = step_bcd;
                shift_d = step_shift;
                step_d  = step_q + 1'b1;
                if (step_q == STEP_LAST) begin
                    idx_d        = start_idx;
                    char_out_d   = digit_to_ascii(step_bcd[{start_idx, 2'b00} +: 4]);
                    char_valid_d = 1'b1;
                    state_d      = EMIT;
                end
            end

            EMIT: begin
                if (char_valid_q && char_ready) begin
                    if (idx_q == '0) begin
                        char_valid_d = 1'b0;
                        state_d      = FINISH;
                    end else begin
                        idx_d      = idx_dec;
                        char_out_d = digit_to_ascii(bcd_q[{idx_dec, 2'b00} +: 4]);
                    end
                end
            end

            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            shift_q      <= '0;
            bcd_q        <= '0;
            step_q       <= '0;
            idx_q        <= '0;
            char_out_q   <= '0;
            char_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q      <= state_d;
            valid_q      <= valid_d;
            shift_q      <= shift_d;
            bcd_q        <= bcd_d;
            step_q       <= step_d;
            idx_q        <= idx_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign char_out   = char_out_q;
    assign char_valid = char_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule : result_bcd_formatter

// File: tb/tb_result_bcd_formatter.sv
// Bench for result_bcd_formatter: two instances (leading zeros suppressed
// and kept) share stimulus; accepted characters are compared with a
// decimal-arithmetic reference model.
module tb_result_bcd_formatter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] result_in;
    logic        result_valid;
    logic        char_ready;

    logic [7:0]  char_out_s, char_out_k;
    logic        char_valid_s, char_valid_k;
    logic        busy_s, busy_k;
    logic        done_s, done_k;

    int total = 0;
    int bad   = 0;

    logic [7:0] q_s[$], q_k[$], exp_s[$], exp_k[$];
    int done_cnt_s = 0, done_cnt_k = 0;
    int vcyc_s = 0, vcyc_k = 0;
    bit stall_s = 0, stall_k = 0;
    logic [7:0] prev_s, prev_k;

    always #5 clk = ~clk;

    result_bcd_formatter #(.DATA_W(16), .DIGITS(5), .SUPPRESS_ZEROS(1'b1)) dut (
        .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid),
        .char_out(char_out_s), .char_valid(char_valid_s), .char_ready(char_ready),
        .busy(busy_s), .done(done_s)
    );

    result_bcd_formatter #(.DATA_W(16), .DIGITS(5), .SUPPRESS_ZEROS(1'b0)) dut_keep (
        .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid),
        .char_out(char_out_k), .char_valid(char_valid_k), .char_ready(char_ready),
        .busy(busy_k), .done(done_k)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal digits by division, optional leading-zero strip.
    function automatic void model(input int v);
        int d[5];
        int t;
        int start;
        t = v;
        for (int i = 0; i < 5; i++) begin
            d[i] = t % 10;
            t    = t / 10;
        end
        exp_s.delete();
        exp_k.delete();
        start = 4;
        while (start > 0 && d[start] == 0) start--;
        for (int i = start; i >= 0; i--) exp_s.push_back(8'(8'h30 + d[i]));
        for (int i = 4; i >= 0; i--) exp_k.push_back(8'(8'h30 + d[i]));
    endfunction

    // Monitors sample mid-cycle: a transfer happens at the next edge when valid && ready.
    always @(negedge clk) begin
        if (reset) begin
            stall_s = 0;
            stall_k = 0;
        end else begin
            if (stall_s) begin
                check("hold_valid_s", char_valid_s, 1);
                check("hold_char_s", char_out_s, prev_s);
            end
            stall_s = char_valid_s && !char_ready;
            prev_s  = char_out_s;
            if (char_valid_s && char_ready) q_s.push_back(char_out_s);
            if (char_valid_s) vcyc_s++;
            if (done_s) done_cnt_s++;

            if (stall_k) begin
                check("hold_valid_k", char_valid_k, 1);
                check("hold_char_k", char_out_k, prev_k);
            end
            stall_k = char_valid_k && !char_ready;
            prev_k  = char_out_k;
            if (char_valid_k && char_ready) q_k.push_back(char_out_k);
            if (char_valid_k) vcyc_k++;
            if (done_k) done_cnt_k++;
        end
    end

    task automatic compare_streams(input string tag);
        check({tag, "_len_s"}, q_s.size(), exp_s.size());
        for (int i = 0; i < exp_s.size() && i < q_s.size(); i++)
            check({tag, "_chr_s"}, q_s[i], exp_s[i]);
        check({tag, "_len_k"}, q_k.size(), exp_k.size());
        for (int i = 0; i < exp_k.size() && i < q_k.size(); i++)
            check({tag, "_chr_k"}, q_k[i], exp_k[i]);
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low on first char, then random.
    task automatic run_txn(input string tag, input logic [15:0] v, input int mode,
                           input bit hold, input int glitch_at, input bit check_lat);
        int n;
        int ds, dk;
        model(int'(v));
        q_s.delete();
        q_k.delete();
        vcyc_s = 0;
        vcyc_k = 0;
        ds = done_cnt_s;
        dk = done_cnt_k;
        result_in    = v;
        result_valid = 1'b1;
        char_ready   = (mode == 0) ? 1'b1 : ((mode == 2) ? 1'b0 : 1'($urandom));
        tick();
        check({tag, "_busy_cap"}, busy_s, 1);
        if (!hold) result_valid = 1'b0;
        result_in = 16'($urandom);
        n = 1;
        while ((done_cnt_s == ds || done_cnt_k == dk) && n < 400) begin
            if (check_lat && n == 16) check({tag, "_lat_early"}, char_valid_s, 0);
            if (check_lat && n == 17) check({tag, "_lat_first"}, char_valid_s, 1);
            if (mode == 1) char_ready = 1'($urandom);
            if (mode == 2) char_ready = (n < 20) ? 1'b0 : 1'($urandom);
            if (glitch_at > 0 && n == glitch_at) begin
                result_valid = 1'b1;
                result_in    = 16'($urandom);
            end
            if (glitch_at > 0 && n == glitch_at + 1) result_valid = hold;
            tick();
            n++;
        end
        check({tag, "_no_timeout"}, (n < 400) ? 1 : 0, 1);
        tick();
        tick();
        check({tag, "_done_once_s"}, done_cnt_s - ds, 1);
        check({tag, "_done_once_k"}, done_cnt_k - dk, 1);
        check({tag, "_busy_end_s"}, busy_s, 0);
        check({tag, "_busy_end_k"}, busy_k, 0);
        check({tag, "_done_low"}, done_s, 0);
        if (mode == 0) begin
            check({tag, "_b2b_s"}, vcyc_s, exp_s.size());
            check({tag, "_b2b_k"}, vcyc_k, exp_k.size());
        end
        compare_streams(tag);
    endtask

    initial begin
        int ds, dk, n;
        logic [15:0] rv;
        reset        = 1'b1;
        result_in    = '0;
        result_valid = 1'b0;
        char_ready   = 1'b0;
        tick();
        tick();
        check("rst_char_out", char_out_s, 8'h00);
        check("rst_char_valid", char_valid_s, 0);
        check("rst_busy", busy_s, 0);
        check("rst_done", done_s, 0);
        reset = 1'b0;
        tick();

        run_txn("t1234", 16'd1234, 0, 0, 0, 1);
        run_txn("tzero", 16'd0, 0, 0, 0, 0);
        run_txn("tmax", 16'd65535, 0, 0, 0, 0);
        run_txn("tten", 16'd10, 0, 0, 0, 0);
        run_txn("tbp", 16'd507, 2, 0, 0, 0);

        // Flag held high through completion must not retrigger.
        run_txn("thold", 16'd300, 0, 1, 0, 0);
        ds = done_cnt_s;
        q_s.delete();
        q_k.delete();
        repeat (25) tick();
        check("hold_no_retrig_done", done_cnt_s - ds, 0);
        check("hold_no_retrig_chars", q_s.size(), 0);
        check("hold_idle_busy", busy_s, 0);
        result_valid = 1'b0;
        tick();
        run_txn("t42", 16'd42, 0, 0, 0, 0);

        // Rising edge during EMIT is ignored.
        run_txn("tglitch", 16'd65535, 0, 0, 18, 0);

        // Reset in the middle of EMIT.
        model(9999);
        q_s.delete();
        q_k.delete();
        result_in    = 16'd9999;
        result_valid = 1'b1;
        char_ready   = 1'b1;
        tick();
        result_valid = 1'b0;
        n = 0;
        while (q_s.size() == 0 && n < 60) begin
            tick();
            n++;
        end
        check("rst_mid_reached", (q_s.size() > 0) ? 1 : 0, 1);
        check("rst_mid_first", (q_s.size() > 0) ? q_s[0] : 8'h00, 8'h39);
        reset = 1'b1;
        tick();
        check("rst_mid_valid_s", char_valid_s, 0);
        check("rst_mid_busy_s", busy_s, 0);
        check("rst_mid_valid_k", char_valid_k, 0);
        check("rst_mid_busy_k", busy_k, 0);
        reset = 1'b0;
        q_s.delete();
        q_k.delete();
        ds = done_cnt_s;
        dk = done_cnt_k;
        repeat (30) tick();
        check("rst_mid_no_done_s", done_cnt_s - ds, 0);
        check("rst_mid_no_done_k", done_cnt_k - dk, 0);
        check("rst_mid_no_chars", q_s.size() + q_k.size(), 0);
        run_txn("t7", 16'd7, 0, 0, 0, 0);

        // Randomized values and handshake patterns.
        for (int i = 0; i < 10; i++) begin
            rv = (i % 3 == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom_range(0, 65535));
            run_txn("trand", rv, int'($urandom_range(0, 2)), 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_result_bcd_formatter

// File: doc/result_bcd_formatter.md
Name: result_bcd_formatter

Overview:
Downstream consumer of the KPN divider stage. It captures the 16-bit quotient when the divider asserts its result flag, then converts it to decimal with a sequential double-dabble. It streams the digits as ASCII characters over a valid/ready handshake to the LCD character writer. One conversion runs per rising edge of the result flag.

Parameters:
DATA_W, 16, width of the binary input value
DIGITS, 5, number of BCD digits held internally (ceil(DATA_W*log10(2)))
SUPPRESS_ZEROS, 1, 1 = drop leading zeros (value 0 still emits a single '0'); 0 = always emit DIGITS characters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
result_in  input  DATA_W  binary quotient from the divider
result_valid  input  1  divider result flag; level signal, may stay high indefinitely
char_out  output  8  ASCII character, 8'h30 + digit
char_valid  output  1  char_out holds a valid character
char_ready  input  1  LCD writer accepts char_out on a cycle where char_valid && char_ready
busy  output  1  high from capture until done
done  output  1  one-cycle pulse after the last character is accepted

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state changes on posedge clk.
- Reset values: char_out=8'h00, char_valid=0, busy=0, done=0. State=IDLE; valid_q=0; shift, BCD and digit-index registers cleared.
- Edge detect: valid_q registers result_valid every cycle. A trigger is result_valid=1 && valid_q=0.
- States: IDLE, CONVERT, EMIT, FINISH.
- IDLE: on trigger at edge N, load result_in into the shift register, clear BCD, set step count=0, busy=1, go to CONVERT. Without a trigger, stay in IDLE.
- CONVERT: one double-dabble step per cycle. Each BCD nibble >=5 gets +3 (combinational), then {bcd,shift} shifts left by 1. After DATA_W steps (edges N+1..N+DATA_W), go to EMIT.
- Start digit on entry to EMIT:
  - SUPPRESS_ZEROS=1: start at the most significant nonzero digit, or at digit 0 if all are zero.
  - SUPPRESS_ZEROS=0: start at digit DIGITS-1.
- EMIT entry: char_valid=1 and char_out=first char, both registered at edge N+DATA_W. First-character latency is DATA_W cycles after the capture edge.
- EMIT handshake: on char_valid && char_ready, advance to the next lower digit and update char_out the same edge. char_valid stays 1 until the transfer that accepts digit 0.
  - While char_ready=0, char_out and char_valid are held stable.
  - Back-to-back acceptance gives one character per cycle.
- After the digit-0 transfer: char_valid=0, state=FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 on the following edge, state=IDLE.
- Triggers during CONVERT/EMIT/FINISH are ignored, not queued. valid_q still tracks result_valid, so a flag held high across completion does not retrigger. A new conversion needs result_valid to fall and rise again.
- result_in is sampled only at the capture edge; later changes have no effect on the current conversion.
- Reset mid-operation: aborts at the next edge with reset values. No done pulse and no further characters.
- Width rules: BCD register is 4*DIGITS bits. The add-3 is applied per nibble before the shift. The max input 2^DATA_W-1 must fit in DIGITS digits.

Decomposition:
- Shared package kpn_lcd_pkg:
  - state enum (IDLE, CONVERT, EMIT, FINISH)
  - ASCII_ZERO = 8'h30
  - LCD_CHAR_W = 8
- One natural sub-module, bin2bcd_step: combinational per-nibble add-3 plus one-bit shift, instantiated once. The FSM, handshake and digit selection stay in result_bcd_formatter.

Test Plan:
1. result_in=16'd1234, result_valid rises, char_ready=1 -> char_valid rises 16 cycles after capture; chars 8'h31, 8'h32, 8'h33, 8'h34 on consecutive cycles; one done pulse; busy low after.
2. result_in=0, SUPPRESS_ZEROS=1 -> single char 8'h30 then done. With SUPPRESS_ZEROS=0 -> five 8'h30 chars.
3. result_in=16'd65535 -> chars 8'h36, 8'h35, 8'h35, 8'h33, 8'h35. result_in=16'd10 -> 8'h31, 8'h30 (inner zero kept).
4. Backpressure on result_in=16'd507: char_ready low 3 cycles on the first char, then random toggling -> char_out stable while not accepted; sequence 8'h35, 8'h30, 8'h37 exactly once each; no drops or duplicates.
5. Hold result_valid high through completion -> exactly one conversion. Drop it for 1 cycle and raise with result_in=16'd42 -> second sequence 8'h34, 8'h32. A rising edge during EMIT -> ignored.
6. Assert reset during EMIT after the first char of 16'd9999 -> next cycle char_valid=0, busy=0, done never pulses. A subsequent trigger with 16'd7 -> clean single 8'h37.
